// File: rtl/axi_pr_queue_mc_if.sv
// Bundle for the PR request queue: Taiga issue/writeback signals, the AXI4-Lite slave port and
// the status outputs. The DUT takes the slave modport; the driving side takes the master modport.
interface axi_pr_queue_mc_if #(
  parameter int unsigned OU_W   = 4,
  parameter int unsigned SLOT_W = 4,
  parameter int unsigned ID_W   = 3
);
  logic              issue_valid;
  logic              issue_ready;
  logic [OU_W-1:0]   issue_ou_id;
  logic [SLOT_W-1:0] issue_slot;
  logic [ID_W-1:0]   issue_id;
  logic              wb_done;
  logic [ID_W-1:0]   wb_id;
  logic              wb_ack;

  logic [3:0]        s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [3:0]        s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  logic              pr_request_pending;
  logic              irq;

  modport master (
    output issue_valid, issue_ou_id, issue_slot, issue_id, wb_ack,
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  issue_ready, wb_done, wb_id,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  pr_request_pending, irq
  );

  modport slave (
    input  issue_valid, issue_ou_id, issue_slot, issue_id, wb_ack,
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output issue_ready, wb_done, wb_id,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output pr_request_pending, irq
  );
endinterface

// File: rtl/axi_pr_queue_mc.sv
// Partial-reconfiguration request queue: Taiga issue pushes {ou_id, slot}, the PR-management CPU
// peeks/pops over AXI4-Lite, with duplicate suppression, flush, and a maskable pending irq.
module axi_pr_queue_mc #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OU_W   = 4,
  parameter int unsigned SLOT_W = 4,
  parameter int unsigned ID_W   = 3,
  parameter bit          DEDUP  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  axi_pr_queue_mc_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = OU_W + SLOT_W;

  typedef logic [EW-1:0] entry_t;
  typedef enum logic {RIdle, RData} rd_state_e;
  typedef enum logic {WIdle, WResp} wr_state_e;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             irq_en_q, irq_en_d;
  logic             waiting_q, waiting_d;
  logic [ID_W-1:0]  wb_id_q, wb_id_d;
  logic [31:0]      rdata_q, rdata_d;
  rd_state_e        rstate_q, rstate_d;
  wr_state_e        wstate_q, wstate_d;

  entry_t      req;
  logic        full, pending, dup, push, enq, pop, ar_acc, aw_acc, ctrl_wr, flush;
  logic [23:0] head_ext;
  logic [31:0] rd_mux;
  logic        unused;

  assign req      = {bus.issue_ou_id, bus.issue_slot};
  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign pending  = (count_q != '0);
  assign head_ext = 24'(mem_q[rd_ptr_q]);
  assign unused   = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0], bus.s_axi_wdata[31:2]};

  // Dedup looks at the queue as it stood before any pop in this same cycle.
  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i] == req)) dup = 1'b1;
    end
  end

  // Gated by rst so every ready is low while reset is asserted.
  assign bus.issue_ready = rst & ~waiting_q & ~full;
  assign push            = bus.issue_valid & bus.issue_ready;
  assign ar_acc          = rst & (rstate_q == RIdle) & bus.s_axi_arvalid;
  assign aw_acc          = rst & (wstate_q == WIdle) & bus.s_axi_awvalid & bus.s_axi_wvalid;
  assign pop             = ar_acc & (bus.s_axi_araddr[3:2] == 2'd2) & pending;
  assign ctrl_wr         = aw_acc & (bus.s_axi_awaddr[3:2] == 2'd3);
  assign flush           = ctrl_wr & bus.s_axi_wdata[1];
  assign enq             = push & ~(DEDUP & dup) & ~flush;

  always_comb begin
    unique case (bus.s_axi_araddr[3:2])
      2'd0:       rd_mux = {16'h0, 8'(count_q), 5'b0, irq_en_q, full, pending};
      2'd1, 2'd2: rd_mux = pending ? {1'b1, 7'b0, head_ext} : 32'h0;
      default:    rd_mux = {31'b0, irq_en_q};
    endcase
  end

  always_comb begin
    vld_d     = vld_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    irq_en_d  = irq_en_q;
    waiting_d = waiting_q;
    wb_id_d   = wb_id_q;
    rdata_d   = rdata_q;
    rstate_d  = rstate_q;
    wstate_d  = wstate_q;

    if (push) begin
      waiting_d = 1'b1;
      wb_id_d   = bus.issue_id;
    end else if (waiting_q && bus.wb_ack) begin
      waiting_d = 1'b0;
    end

    if (ctrl_wr) irq_en_d = bus.s_axi_wdata[0];

    if (flush) begin
      vld_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (enq) begin
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      count_d = count_q + (AW + 1)'(enq) - (AW + 1)'(pop);
    end

    unique case (rstate_q)
      RIdle: if (ar_acc) begin
        rdata_d  = rd_mux;
        rstate_d = RData;
      end
      default: if (bus.s_axi_rready) rstate_d = RIdle;
    endcase

    unique case (wstate_q)
      WIdle:   if (aw_acc) wstate_d = WResp;
      default: if (bus.s_axi_bready) wstate_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      irq_en_q  <= 1'b0;
      waiting_q <= 1'b0;
      wb_id_q   <= '0;
      rdata_q   <= '0;
      rstate_q  <= RIdle;
      wstate_q  <= WIdle;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      irq_en_q  <= irq_en_d;
      waiting_q <= waiting_d;
      wb_id_q   <= wb_id_d;
      rdata_q   <= rdata_d;
      rstate_q  <= rstate_d;
      wstate_q  <= wstate_d;
    end
  end

  // Payload storage needs no reset; vld_q/count_q qualify every use.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= req;
  end

  assign bus.wb_done            = waiting_q;
  assign bus.wb_id              = wb_id_q;
  assign bus.s_axi_arready      = ar_acc;
  assign bus.s_axi_rvalid       = (rstate_q == RData);
  assign bus.s_axi_rdata        = rdata_q;
  assign bus.s_axi_rresp        = 2'b00;
  assign bus.s_axi_awready      = aw_acc;
  assign bus.s_axi_wready       = aw_acc;
  assign bus.s_axi_bvalid       = (wstate_q == WResp);
  assign bus.s_axi_bresp        = 2'b00;
  assign bus.pr_request_pending = pending;
  assign bus.irq                = irq_en_q & pending;
endmodule

// File: tb/tb_axi_pr_queue_mc.sv
// Directed bench for axi_pr_queue_mc: a queue model plus writeback-id and read-data scoreboards;
// a second instance with DEDUP=0 shows identical requests are all enqueued.
module tb_axi_pr_queue_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_pr_queue_mc_if #(.OU_W(4), .SLOT_W(4), .ID_W(3)) bus ();
  axi_pr_queue_mc_if #(.OU_W(4), .SLOT_W(4), .ID_W(3)) bus0 ();

  axi_pr_queue_mc #(.DEPTH(4), .OU_W(4), .SLOT_W(4), .ID_W(3), .DEDUP(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  axi_pr_queue_mc #(.DEPTH(4), .OU_W(4), .SLOT_W(4), .ID_W(3), .DEDUP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]  mq[$];
  logic [2:0]  wbq[$];
  logic [31:0] rdq[$];
  logic        irq_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(mq.size()), 5'b0, irq_m, mq.size() == 4, mq.size() != 0};
  endfunction

  function automatic logic [31:0] m_peek();
    if (mq.size() == 0) return 32'h0;
    return {8'h80, 16'h0, mq[0]};
  endfunction

  task automatic wb_check(input int hold);
    logic [2:0] e;
    e = wbq.pop_front();
    for (int i = 0; i <= hold; i++) begin
      chk("wb_done", 32'(bus.wb_done), 32'd1);
      chk("wb_id", 32'(bus.wb_id), 32'(e));
      if (i < hold) @(negedge clk);
    end
    bus.wb_ack = 1'b1;
    @(negedge clk);
    bus.wb_ack = 1'b0;
    chk("wb_done_clr", 32'(bus.wb_done), 32'd0);
  endtask

  task automatic push(input logic [3:0] ou, input logic [3:0] slot, input logic [2:0] id,
                      input int hold);
    bit d;
    @(negedge clk);
    chk("issue_ready", 32'(bus.issue_ready), 32'd1);
    bus.issue_valid = 1'b1;
    bus.issue_ou_id = ou;
    bus.issue_slot  = slot;
    bus.issue_id    = id;
    d = 1'b0;
    foreach (mq[i]) if (mq[i] == {ou, slot}) d = 1'b1;
    if (!d) mq.push_back({ou, slot});
    wbq.push_back(id);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    wb_check(hold);
  endtask

  task automatic axi_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    int n;
    rdq.push_back(exp);
    @(negedge clk);
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b1;
    #1;
    chk({tag, "_arready"}, 32'(bus.s_axi_arready), 32'd1);
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s_axi_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rvalid"}, 32'(bus.s_axi_rvalid), 32'd1);
    chk(tag, bus.s_axi_rdata, rdq.pop_front());
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
    chk({tag, "_rvalid_clr"}, 32'(bus.s_axi_rvalid), 32'd0);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.s_axi_awaddr  = addr;
    bus.s_axi_wdata   = data;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    bus.s_axi_bready  = 1'b1;
    #1;
    chk("awready", 32'(bus.s_axi_awready), 32'd1);
    chk("wready", 32'(bus.s_axi_wready), 32'd1);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    chk("bvalid", 32'(bus.s_axi_bvalid), 32'd1);
    chk("bresp", 32'(bus.s_axi_bresp), 32'd0);
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    chk("bvalid_clr", 32'(bus.s_axi_bvalid), 32'd0);
    if (addr[3:2] == 2'd3) begin
      irq_m = data[0];
      if (data[1]) mq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    {bus.issue_valid, bus.issue_ou_id, bus.issue_slot, bus.issue_id, bus.wb_ack} = '0;
    {bus.s_axi_awaddr, bus.s_axi_awvalid, bus.s_axi_wdata, bus.s_axi_wvalid} = '0;
    {bus.s_axi_bready, bus.s_axi_araddr, bus.s_axi_arvalid, bus.s_axi_rready} = '0;
    {bus0.issue_valid, bus0.issue_ou_id, bus0.issue_slot, bus0.issue_id, bus0.wb_ack} = '0;
    {bus0.s_axi_awaddr, bus0.s_axi_awvalid, bus0.s_axi_wdata, bus0.s_axi_wvalid} = '0;
    {bus0.s_axi_bready, bus0.s_axi_araddr, bus0.s_axi_arvalid, bus0.s_axi_rready} = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("rst_wb_done", 32'(bus.wb_done), 32'd0);
    chk("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    chk("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
    chk("rst_pending", 32'(bus.pr_request_pending), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    rst = 1'b1;

    // Single push, writeback held until ack.
    push(4'd3, 4'd1, 3'd2, 3);
    axi_read("status_one", 4'h0, 32'h0000_0101);
    chk("pending_one", 32'(bus.pr_request_pending), 32'd1);

    // Duplicate suppressed but still written back.
    push(4'd3, 4'd1, 3'd5, 0);
    axi_read("status_dedup", 4'h0, 32'h0000_0101);

    // irq enable then flush.
    axi_write(4'hC, 32'h1);
    chk("irq_on", 32'(bus.irq), 32'd1);
    axi_read("status_irqen", 4'h0, 32'h0000_0105);
    axi_read("ctrl_rd", 4'hC, 32'h1);
    axi_write(4'hC, 32'h2);
    chk("irq_off", 32'(bus.irq), 32'd0);
    axi_read("status_flush", 4'h0, 32'h0);
    axi_read("peek_flush", 4'h4, 32'h0);

    // Fill to DEPTH, then drain in order.
    push(4'd1, 4'd2, 3'd0, 0);
    push(4'd2, 4'd3, 3'd1, 0);
    push(4'd4, 4'd5, 3'd2, 0);
    push(4'd6, 4'd7, 3'd3, 0);
    chk("full_issue_ready", 32'(bus.issue_ready), 32'd0);
    axi_read("status_full", 4'h0, 32'h0000_0403);
    axi_read("peek_full", 4'h4, 32'h8000_0012);
    for (int i = 0; i < 4; i++) begin
      e = m_peek();
      void'(mq.pop_front());
      axi_read("pop", 4'h8, e);
    end
    axi_read("pop_empty", 4'h8, 32'h0);
    axi_read("status_drained", 4'h0, m_status());

    // Push and pop in the same cycle at count=1.
    push(4'd9, 4'd9, 3'd4, 0);
    @(negedge clk);
    bus.issue_valid   = 1'b1;
    bus.issue_ou_id   = 4'hA;
    bus.issue_slot    = 4'h1;
    bus.issue_id      = 3'd6;
    bus.s_axi_araddr  = 4'h8;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b1;
    wbq.push_back(3'd6);
    rdq.push_back(32'h8000_0099);
    void'(mq.pop_front());
    mq.push_back(8'hA1);
    @(negedge clk);
    bus.issue_valid   = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    chk("pp_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
    chk("pp_rdata", bus.s_axi_rdata, rdq.pop_front());
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
    wb_check(0);
    axi_read("status_pp", 4'h0, 32'h0000_0101);
    axi_read("peek_pp", 4'h4, 32'h8000_00A1);

    // Write to a read-only address is ignored.
    axi_write(4'h0, 32'hFFFF_FFFF);
    axi_read("status_ro", 4'h0, m_status());
    chk("irq_ro", 32'(bus.irq), 32'd0);

    // DEDUP=0 instance: four identical requests fill the queue.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus0.issue_valid = 1'b1;
      bus0.issue_ou_id = 4'd3;
      bus0.issue_slot  = 4'd1;
      bus0.issue_id    = 3'(i);
      @(negedge clk);
      bus0.issue_valid = 1'b0;
      chk("nd_wb_id", 32'(bus0.wb_id), 32'(i));
      bus0.wb_ack = 1'b1;
      @(negedge clk);
      bus0.wb_ack = 1'b0;
    end
    chk("nd_full_ready", 32'(bus0.issue_ready), 32'd0);
    chk("nd_pending", 32'(bus0.pr_request_pending), 32'd1);

    // Stalled read holds data; reset mid-read aborts it.
    @(negedge clk);
    bus.s_axi_araddr  = 4'h4;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b0;
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
      chk("stall_rdata", bus.s_axi_rdata, 32'h8000_00A1);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    chk("abort_pending", 32'(bus.pr_request_pending), 32'd0);
    rst = 1'b1;
    mq.delete();
    irq_m = 1'b0;
    axi_read("status_after_rst", 4'h0, m_status());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
